vehicle_light_controller: RTL and testbench
===========================================

VEHICLE_LIGHT_CONTROLLER -- requirements
Module: vehicle_light_controller

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent light channels (1..16).
REQ-002 SHALL have parameter DUTY_W, default 10: duty/level width; PWM period = 2^DUTY_W-1 clocks.
REQ-003 SHALL have parameter DIM_DUTY, default 31: level used in DIM mode (< 2^DUTY_W-1).
REQ-004 SHALL have parameter RAMP_DIV, default 50000: clocks per ramp tick (1 ms at 50 MHz).
REQ-005 SHALL have parameter RAMP_STEP, default 32: maximum level change per ramp tick.
REQ-006 SHALL have parameter BLINK_HALF, default 16750000: clocks per blink half-period.
REQ-007 SHALL have port c50M  in  1  system clock, the only clock.
REQ-008 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-009 SHALL have port mode_i  in  2*NUM_CH  per-channel mode; channel i in bits [2i+1:2i].
REQ-010 SHALL have port override_i  in  NUM_CH  per-channel force-full request (e.g. brake).
REQ-011 SHALL have port pwm_o  out  NUM_CH  registered PWM drive per channel.
REQ-012 SHALL have port level_o  out  NUM_CH*DUTY_W  current applied level per channel.
REQ-013 SHALL have port blink_phase_o  out  1  current blink phase (1 = lit).

Function
REQ-014 Mode encoding SHALL be OFF=0, DIM=1, ON=2, BLINK=3.
REQ-015 Target level SHALL be: OFF 0; DIM DIM_DUTY; ON MAX (2^DUTY_W-1); BLINK MAX when blink_phase_o=1, else 0.
REQ-016 One shared PWM counter SHALL count 0..MAX-1 and wrap to 0.
REQ-017 pwm_o[i] SHALL be registered (cnt < level[i]): level 0 never high, level MAX always high, no glitch pulse at wrap.
REQ-018 A free-running tick counter SHALL assert a one-cycle ramp tick every RAMP_DIV clocks.
REQ-019 On each tick, a non-BLINK, non-override channel SHALL move level toward target by min(RAMP_STEP, |target-level|), never overshooting; no change between ticks.
REQ-020 Channel in BLINK mode (no override) SHALL load target directly each cycle, bypassing ramp.
REQ-021 override_i[i]=1 SHALL set level[i]=MAX on the next clock regardless of mode or tick; on release, normal ramp/blink resumes from MAX.
REQ-022 Mode change SHALL take effect on next tick (ramped) or next clock (BLINK/override); mid-ramp target change SHALL redirect ramp from current level.
REQ-023 Blink timer SHALL be held at count 0, phase 1, while no channel is in BLINK; once any channel is in BLINK it counts, toggling phase every BLINK_HALF clocks.
REQ-024 Blink timer SHALL return to held state one clock after last BLINK channel leaves BLINK.
REQ-025 Level arithmetic SHALL use DUTY_W+1 bits internally; level_o SHALL never exceed MAX.
REQ-026 Simultaneous override and tick: override SHALL win.

Reset
REQ-027 While reset=1: all levels 0, pwm_o 0, level_o 0, PWM/tick/blink counters 0, blink_phase_o 1.
REQ-028 Reset mid-ramp or mid-blink SHALL abort immediately; after release, ramps start from 0.

Structure
REQ-029 Package vehicle_light_pkg SHALL hold the mode enum (light_mode_t) and mode constants.
REQ-030 Per-channel level/ramp/compare logic SHALL be sub-module light_pwm_channel, instantiated NUM_CH times by generate; PWM, tick and blink counters stay in top level, shared.

Verification (bench params: DUTY_W=4, MAX=15, DIM_DUTY=3, RAMP_DIV=4, RAMP_STEP=4, BLINK_HALF=20, NUM_CH=2)
REQ-031 Reset then ch0 ON -> level_o ch0 steps 0,4,8,12,15 on successive ticks; then pwm_o ch0 constant 1.
REQ-032 ch0 ON at 15 then DIM -> steps 11,7,3 and holds; pwm_o high 3 of every 15 clocks.
REQ-033 ch1 BLINK from idle -> blink_phase_o=1 immediately, level 15 for 20 clocks, 0 for 20 clocks, repeating; leaving BLINK -> phase held 1 after one clock.
REQ-034 ch0 DIM at 3, override pulse 10 clocks -> level 15 next clock, pwm_o solid high; after release ramps 11,7,3.
REQ-035 Assert reset mid-ramp (level 8) -> level_o 0 and pwm_o 0 asynchronously; after release ramp restarts 0,4,...
REQ-036 Override asserted on same clock as tick while OFF -> level 15, never 4.

Source files
------------

// File: rtl/vehicle_light_pkg.sv
// Shared mode encoding for the vehicle light controller and its channel slices.
package vehicle_light_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_DIM   = 2'd1,
        MODE_ON    = 2'd2,
        MODE_BLINK = 2'd3
    } light_mode_t;

    localparam int MODE_W = 2;

    function automatic logic is_ramped(input light_mode_t m);
        return m != MODE_BLINK;
    endfunction

endpackage

// File: rtl/vehicle_light_controller_if.sv
// Bundle of the controller's mode/override requests and PWM/level/phase observations.
interface vehicle_light_controller_if #(
    parameter int NUM_CH = 4,
    parameter int DUTY_W = 10
);
    logic [2*NUM_CH-1:0]      mode;
    logic [NUM_CH-1:0]        override_req;
    logic [NUM_CH-1:0]        pwm;
    logic [NUM_CH*DUTY_W-1:0] level;
    logic                     blink_phase;

    modport master (output mode, output override_req,
                    input pwm, input level, input blink_phase);
    modport slave  (input mode, input override_req,
                    output pwm, output level, output blink_phase);
endinterface

// File: rtl/light_pwm_channel.sv
// One light channel: level ramp/blink/override tracking and registered PWM compare.
// Level updates one clock after a tick/override/blink phase; pwm lags level by one clock; no backpressure.
module light_pwm_channel
    import vehicle_light_pkg::*;
#(
    parameter int DUTY_W    = 10,
    parameter int DIM_DUTY  = 31,
    parameter int RAMP_STEP = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  light_mode_t       mode,
    input  logic              override_req,
    input  logic              tick,
    input  logic              blink_phase,
    input  logic [DUTY_W-1:0] cnt,
    output logic [DUTY_W-1:0] level,
    output logic              pwm
);

    localparam int MAX_I  = 2**DUTY_W - 1;
    localparam int STEP_I = (RAMP_STEP > MAX_I) ? MAX_I : RAMP_STEP;
    localparam logic [DUTY_W:0] MAX_W  = (DUTY_W+1)'(MAX_I);
    localparam logic [DUTY_W:0] DIM_W  = (DUTY_W+1)'(DIM_DUTY);
    localparam logic [DUTY_W:0] STEP_W = (DUTY_W+1)'(STEP_I);

    logic [DUTY_W:0] target;
    logic [DUTY_W:0] cur;
    logic [DUTY_W:0] diff;
    logic [DUTY_W:0] delta;
    logic [DUTY_W:0] next_lvl;

    always_comb begin
        target = '0;
        case (mode)
            MODE_DIM:   target = DIM_W;
            MODE_ON:    target = MAX_W;
            MODE_BLINK: target = blink_phase ? MAX_W : '0;
            default:    target = '0;
        endcase

        cur      = {1'b0, level};
        diff     = (target > cur) ? (target - cur) : (cur - target);
        delta    = (diff > STEP_W) ? STEP_W : diff;
        next_lvl = cur;

        // Override beats blink and ramp, including on a tick cycle.
        if (override_req) begin
            next_lvl = MAX_W;
        end else if (!is_ramped(mode)) begin
            next_lvl = target;
        end else if (tick) begin
            next_lvl = (target > cur) ? (cur + delta) : (cur - delta);
        end

        if (next_lvl > MAX_W) begin
            next_lvl = MAX_W;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
            pwm   <= 1'b0;
        end else begin
            level <= next_lvl[DUTY_W-1:0];
            pwm   <= (cnt < level);
        end
    end

endmodule

// File: rtl/vehicle_light_controller.sv
// Multi-channel light controller: shared PWM/ramp-tick/blink timers driving per-channel slices.
// Outputs registered (level 1 clock, pwm 2 clocks after a change); free-running, no backpressure.
module vehicle_light_controller
    import vehicle_light_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DUTY_W     = 10,
    parameter int DIM_DUTY   = 31,
    parameter int RAMP_DIV   = 50000,
    parameter int RAMP_STEP  = 32,
    parameter int BLINK_HALF = 16750000
) (
    input  logic                     c50M,
    input  logic                     reset,
    input  logic [2*NUM_CH-1:0]      mode_i,
    input  logic [NUM_CH-1:0]        override_i,
    output logic [NUM_CH-1:0]        pwm_o,
    output logic [NUM_CH*DUTY_W-1:0] level_o,
    output logic                     blink_phase_o
);

    localparam int TICK_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [DUTY_W-1:0]  PWM_LAST   = DUTY_W'(2**DUTY_W - 2);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(RAMP_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [DUTY_W-1:0]  pwm_cnt;
    logic [TICK_W-1:0]  tick_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               tick;
    logic               any_blink;

    assign tick = (tick_cnt == TICK_LAST);

    always_comb begin
        any_blink = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (light_mode_t'(mode_i[2*i +: 2]) == MODE_BLINK) begin
                any_blink = 1'b1;
            end
        end
    end

    always_ff @(posedge c50M or posedge reset) begin
        if (reset) begin
            pwm_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    // Blink timer idles at count 0 / lit so a newly blinking channel starts lit.
    always_ff @(posedge c50M or posedge reset) begin
        if (reset) begin
            blink_cnt     <= '0;
            blink_phase_o <= 1'b1;
        end else if (!any_blink) begin
            blink_cnt     <= '0;
            blink_phase_o <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt     <= '0;
            blink_phase_o <= ~blink_phase_o;
        end else begin
            blink_cnt     <= blink_cnt + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        light_pwm_channel #(
            .DUTY_W    (DUTY_W),
            .DIM_DUTY  (DIM_DUTY),
            .RAMP_STEP (RAMP_STEP)
        ) u_ch (
            .clk          (c50M),
            .rst          (reset),
            .mode         (light_mode_t'(mode_i[2*gi +: 2])),
            .override_req (override_i[gi]),
            .tick         (tick),
            .blink_phase  (blink_phase_o),
            .cnt          (pwm_cnt),
            .level        (level_o[gi*DUTY_W +: DUTY_W]),
            .pwm          (pwm_o[gi])
        );
    end

endmodule

// File: tb/tb_vehicle_light_controller.sv
// Directed and randomized checks of vehicle_light_controller against an integer reference model.
module tb_vehicle_light_controller;

    localparam int NCH        = 2;
    localparam int DW         = 4;
    localparam int MAXV       = 15;
    localparam int DIM        = 3;
    localparam int RAMP_DIV   = 4;
    localparam int STEP       = 4;
    localparam int BLINK_HALF = 20;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    int m_lvl [NCH];
    int m_pwm [NCH];
    int m_pcnt, m_tcnt, m_bcnt, m_phase;

    vehicle_light_controller_if #(.NUM_CH(NCH), .DUTY_W(DW)) bus ();

    vehicle_light_controller #(
        .NUM_CH(NCH), .DUTY_W(DW), .DIM_DUTY(DIM), .RAMP_DIV(RAMP_DIV),
        .RAMP_STEP(STEP), .BLINK_HALF(BLINK_HALF)
    ) dut (
        .c50M          (clk),
        .reset         (rst),
        .mode_i        (bus.mode),
        .override_i    (bus.override_req),
        .pwm_o         (bus.pwm),
        .level_o       (bus.level),
        .blink_phase_o (bus.blink_phase)
    );

    always #5 clk = ~clk;

    function automatic int lvl_of(input int ch);
        return int'(bus.level[ch*DW +: DW]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_lvl[c] = 0;
            m_pwm[c] = 0;
        end
        m_pcnt = 0; m_tcnt = 0; m_bcnt = 0; m_phase = 1;
    endtask

    // Rules applied at one clock edge, from the values held just before it.
    task automatic model_edge();
        int tick, any, md, tgt, d;
        if (rst) begin
            model_reset();
            return;
        end
        tick = (m_tcnt == RAMP_DIV - 1);
        any  = 0;
        for (int c = 0; c < NCH; c++) if (bus.mode[2*c +: 2] == 2'd3) any = 1;
        for (int c = 0; c < NCH; c++) begin
            m_pwm[c] = (m_pcnt < m_lvl[c]) ? 1 : 0;
            md  = int'(bus.mode[2*c +: 2]);
            tgt = (md == 0) ? 0 : (md == 1) ? DIM : (md == 2) ? MAXV : (m_phase ? MAXV : 0);
            if (bus.override_req[c]) m_lvl[c] = MAXV;
            else if (md == 3) m_lvl[c] = tgt;
            else if (tick) begin
                d = (tgt > m_lvl[c]) ? tgt - m_lvl[c] : m_lvl[c] - tgt;
                if (d > STEP) d = STEP;
                m_lvl[c] = (tgt > m_lvl[c]) ? m_lvl[c] + d : m_lvl[c] - d;
            end
        end
        m_pcnt = (m_pcnt + 1) % MAXV;
        m_tcnt = (m_tcnt + 1) % RAMP_DIV;
        if (any) begin
            m_bcnt++;
            if (m_bcnt == BLINK_HALF) begin
                m_bcnt  = 0;
                m_phase = 1 - m_phase;
            end
        end else begin
            m_bcnt  = 0;
            m_phase = 1;
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("model_level_ch%0d", c), lvl_of(c), m_lvl[c]);
            check($sformatf("model_pwm_ch%0d", c), bus.pwm[c], m_pwm[c]);
        end
        check("model_phase", bus.blink_phase, m_phase);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_mode(input int ch, input int m);
        bus.mode[2*ch +: 2] = 2'(m);
    endtask

    task automatic wait_level(input int ch, input int exp_v, input string tag);
        int prev;
        prev = lvl_of(ch);
        for (int k = 0; k < 3 * RAMP_DIV; k++) begin
            step();
            if (lvl_of(ch) != prev) break;
        end
        check(tag, lvl_of(ch), exp_v);
    endtask

    initial begin
        int highs;
        int guard;
        rst = 1'b1;
        bus.mode = '0;
        bus.override_req = '0;
        model_reset();
        repeat (3) step();
        check("reset_level0", lvl_of(0), 0);
        check("reset_pwm", bus.pwm, 0);
        check("reset_phase", bus.blink_phase, 1);

        // Ramp up from reset.
        rst = 1'b0;
        set_mode(0, 2);
        wait_level(0, 4, "on_ramp_4");
        wait_level(0, 8, "on_ramp_8");
        wait_level(0, 12, "on_ramp_12");
        wait_level(0, 15, "on_ramp_15");
        for (int k = 0; k < 30; k++) begin
            step();
            check("on_pwm_solid", bus.pwm[0], 1);
        end

        // Ramp down to DIM and hold.
        set_mode(0, 1);
        wait_level(0, 11, "dim_ramp_11");
        wait_level(0, 7, "dim_ramp_7");
        wait_level(0, 3, "dim_ramp_3");
        repeat (20) step();
        check("dim_hold", lvl_of(0), 3);
        highs = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            highs += int'(bus.pwm[0]);
        end
        check("dim_duty_highs", highs, 3);

        // Override pulse from DIM.
        bus.override_req[0] = 1'b1;
        step();
        check("ovr_level_next", lvl_of(0), 15);
        for (int k = 1; k < 10; k++) begin
            step();
            check("ovr_pwm_solid", bus.pwm[0], 1);
        end
        bus.override_req[0] = 1'b0;
        wait_level(0, 11, "ovr_rel_11");
        wait_level(0, 7, "ovr_rel_7");
        wait_level(0, 3, "ovr_rel_3");

        // Blink on ch1 from idle.
        check("blink_idle_phase", bus.blink_phase, 1);
        set_mode(1, 3);
        for (int k = 1; k <= 60; k++) begin
            step();
            check("blink_level", lvl_of(1), (((k - 1) / 20) % 2 == 0) ? 15 : 0);
        end
        check("blink_phase_before_leave", bus.blink_phase, 0);
        set_mode(1, 0);
        step();
        check("blink_leave_phase", bus.blink_phase, 1);
        repeat (25) step();
        check("blink_held_phase", bus.blink_phase, 1);

        // Async reset in the middle of a ramp.
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_mode(0, 2);
        wait_level(0, 4, "rst_pre_4");
        wait_level(0, 8, "rst_pre_8");
        rst = 1'b1;
        #1;
        check("async_rst_level", lvl_of(0), 0);
        check("async_rst_pwm", bus.pwm[0], 0);
        check("async_rst_phase", bus.blink_phase, 1);
        model_reset();
        step();
        rst = 1'b0;
        check("rst_restart_0", lvl_of(0), 0);
        wait_level(0, 4, "rst_restart_4");

        // Override coinciding with a tick while starting from OFF.
        set_mode(0, 0);
        guard = 0;
        while (m_lvl[0] != 0 && guard < 40) begin
            step();
            guard++;
        end
        check("off_settled", lvl_of(0), 0);
        guard = 0;
        while (m_tcnt != RAMP_DIV - 1 && guard < 2 * RAMP_DIV) begin
            step();
            guard++;
        end
        set_mode(0, 2);
        bus.override_req[0] = 1'b1;
        step();
        check("ovr_beats_tick", lvl_of(0), 15);
        bus.override_req[0] = 1'b0;
        set_mode(0, 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(7) == 0) bus.mode = 4'($urandom);
            bus.override_req = ($urandom_range(15) == 0) ? 2'($urandom) : 2'b00;
            rst = ($urandom_range(99) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
